abs_diff_err_sweep: RTL and testbench
=====================================

// Module: abs_diff_err_sweep
// PURPOSE
//  Exhaustive error-evaluation sequencer for one WIDTH-bit absolute-difference datapath (exact or approximate).
//  Drives every (a,b) input pair into the external DUT and samples the DUT result.
//  Compares each result against an internal exact |a-b| and accumulates error metrics.
//  Sits in the evaluation harness between the control/CSR side and the combinational or pipelined abs_diff netlist.
// PARAMETERS
//  WIDTH  6  operand and result width; sweep length N = 2**(2*WIDTH)
//  LAT    0  DUT latency in cycles (0 = purely combinational DUT, sampled in the same cycle)
// PORTS
//  clk        in   1          clock; all state on rising edge
//  rst        in   1          asynchronous, active-high reset
//  start      in   1          pulse; begins a sweep when idle
//  abort      in   1          synchronous; cancels a sweep in progress
//  busy       out  1          high while a sweep or drain is in progress
//  done       out  1          one-cycle pulse; metrics are final
//  dut_a      out  WIDTH      DUT operand a (= cnt[2*WIDTH-1:WIDTH])
//  dut_b      out  WIDTH      DUT operand b (= cnt[WIDTH-1:0])
//  dut_valid  out  1          high while dut_a/dut_b carry a sweep vector
//  dut_y      in   WIDTH      DUT result for the vector applied LAT cycles earlier
//  err_count  out  2*WIDTH+1  number of vectors with dut_y != exact
//  err_max    out  WIDTH      largest |dut_y - exact|
//  err_sum    out  3*WIDTH    sum of |dut_y - exact| (cannot overflow: N*(2**WIDTH-1) < 2**(3*WIDTH))
//  worst_vec  out  2*WIDTH    {a,b} of the first vector reaching err_max
// BEHAVIOUR
//  Reset: state IDLE, cnt=0, dut_a/dut_b=0, dut_valid=0, busy=0, done=0, all metrics 0, delay line cleared.
//  States: IDLE, RUN, DRAIN, DONE.
//  - IDLE: start=1 clears cnt, metrics and the LAT-deep delay line, then moves to RUN.
//  - RUN: drives dut_a/dut_b from cnt with dut_valid=1 and increments cnt each cycle.
//    Vector k is driven in RUN cycle k (k = 0..N-1).
//    After driving cnt = N-1, cnt wraps to 0 and the state moves to DRAIN (LAT>0) or DONE (LAT=0).
//  - DRAIN: holds dut_valid=0 and dut_a/dut_b at their last value for exactly LAT cycles, then moves to DONE.
//  - DONE: done=1 for one cycle, then IDLE. Metrics hold until the next start or rst.
//  busy = 1 in RUN and DRAIN only.
//  Timing: if start is sampled at edge 0, done is high in cycle N+LAT+1 (N=4096 at WIDTH=6).
//  Scoring: {a,b,valid} pass through a LAT-stage register pipe; LAT=0 scores the current vector.
//  - When the delayed valid is high: exact = |a_d - b_d| (unsigned, WIDTH bits); e = |dut_y - exact|.
//  - If e != 0: err_count += 1 and err_sum += e.
//  - If e > err_max (strictly greater): err_max <= e and worst_vec <= {a_d,b_d}, so ties keep the earliest vector.
//  - All metric updates take effect at the end of the scoring cycle.
//  Boundary conditions:
//  - start while busy or in DONE: ignored.
//  - abort in RUN/DRAIN: next state IDLE, dut_valid=0, delay line flushed, no done pulse; metrics hold partial values and are not valid.
//  - abort and start in the same IDLE cycle: abort wins and the sweep does not start.
//  - abort in IDLE/DONE: no effect.
//  - rst mid-sweep: immediate return to reset values.
//  - dut_y is ignored whenever the delayed valid is 0.
// TESTING
//  1. Ideal DUT (dut_y = exact), LAT=0: start -> done at cycle 4097; err_count=0, err_max=0, err_sum=0, worst_vec=0.
//  2. DUT with result bit0 stuck-at-0: err_count=2048, err_max=1, err_sum=2048, worst_vec=12'h001 (a=0,b=1).
//  3. DUT output tied to 0: err_count=4032, err_max=63, err_sum=87360, worst_vec=12'h03F.
//  4. Ideal DUT behind 2 register stages, LAT=2: done at cycle 4099; busy high cycles 1..4098; all metrics 0.
//  5. abort at RUN cycle 100 -> IDLE next cycle, no done. A following start produces a full, correct sweep (repeat test 3 values).
//  6. start pulsed mid-run -> ignored and the sweep length is unchanged. rst at cycle 2000 -> outputs at reset values, busy=0.

Source files
------------

// File: rtl/abs_diff_err_sweep.sv
// Exhaustive error sweep for a WIDTH-bit |a-b| datapath: drives every (a,b) pair,
// scores the DUT result against the exact value and accumulates error metrics.
module abs_diff_err_sweep #(
  parameter int WIDTH = 6,
  parameter int LAT   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_dut_a,
  output logic [WIDTH-1:0]     o_dut_b,
  output logic                 o_dut_valid,
  input  logic [WIDTH-1:0]     i_dut_y,
  output logic [2*WIDTH:0]     o_err_count,
  output logic [WIDTH-1:0]     o_err_max,
  output logic [3*WIDTH-1:0]   o_err_sum,
  output logic [2*WIDTH-1:0]   o_worst_vec
);

  localparam int CW = 2 * WIDTH;
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e             r_state;
  state_e             w_nextState;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_vecHold;
  logic [CW-1:0]      w_vec;
  logic [DW-1:0]      r_drainCnt;
  logic               w_startSweep;
  logic               w_abortSweep;
  logic               w_lastVec;
  logic               w_drainEnd;
  logic [WIDTH-1:0]   w_dA;
  logic [WIDTH-1:0]   w_dB;
  logic               w_dValid;
  logic [WIDTH-1:0]   w_exact;
  logic [WIDTH-1:0]   w_err;
  logic [CW:0]        r_errCount;
  logic [WIDTH-1:0]   r_errMax;
  logic [3*WIDTH-1:0] r_errSum;
  logic [CW-1:0]      r_worstVec;

  // Abort always beats start, so a simultaneous start/abort in IDLE does nothing.
  assign w_startSweep = (r_state == IDLE) && i_start && !i_abort;
  assign w_abortSweep = ((r_state == RUN) || (r_state == DRAIN)) && i_abort;
  assign w_lastVec    = (r_cnt == {CW{1'b1}});
  assign w_drainEnd   = (r_drainCnt == DW'(LAT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_dut_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_startSweep) w_nextState = RUN;
      end
      RUN: begin
        o_busy      = 1'b1;
        o_dut_valid = 1'b1;
        if (i_abort)        w_nextState = IDLE;
        else if (w_lastVec) w_nextState = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (i_abort)         w_nextState = IDLE;
        else if (w_drainEnd) w_nextState = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The held vector keeps the operands stable once RUN ends (drain, abort, idle).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_vecHold  <= '0;
      r_drainCnt <= '0;
    end else begin
      if (w_startSweep) begin
        r_cnt <= '0;
      end else if ((r_state == RUN) && !i_abort) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == RUN) r_vecHold <= r_cnt;
      if (r_state == DRAIN) r_drainCnt <= r_drainCnt + 1'b1;
      else                  r_drainCnt <= '0;
    end
  end

  assign w_vec   = (r_state == RUN) ? r_cnt : r_vecHold;
  assign o_dut_a = w_vec[CW-1:WIDTH];
  assign o_dut_b = w_vec[WIDTH-1:0];

  generate
    if (LAT == 0) begin : g_noPipe
      assign w_dA     = o_dut_a;
      assign w_dB     = o_dut_b;
      assign w_dValid = o_dut_valid;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipeA [LAT];
      logic [WIDTH-1:0] r_pipeB [LAT];
      logic             r_pipeV [LAT];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < LAT; i++) begin
            r_pipeA[i] <= '0;
            r_pipeB[i] <= '0;
            r_pipeV[i] <= 1'b0;
          end
        end else if (w_startSweep || w_abortSweep) begin
          for (int i = 0; i < LAT; i++) begin
            r_pipeA[i] <= '0;
            r_pipeB[i] <= '0;
            r_pipeV[i] <= 1'b0;
          end
        end else begin
          r_pipeA[0] <= o_dut_a;
          r_pipeB[0] <= o_dut_b;
          r_pipeV[0] <= o_dut_valid;
          for (int i = 1; i < LAT; i++) begin
            r_pipeA[i] <= r_pipeA[i-1];
            r_pipeB[i] <= r_pipeB[i-1];
            r_pipeV[i] <= r_pipeV[i-1];
          end
        end
      end

      assign w_dA     = r_pipeA[LAT-1];
      assign w_dB     = r_pipeB[LAT-1];
      assign w_dValid = r_pipeV[LAT-1];
    end
  endgenerate

  assign w_exact = (w_dA >= w_dB) ? (w_dA - w_dB) : (w_dB - w_dA);
  assign w_err   = (i_dut_y >= w_exact) ? (i_dut_y - w_exact) : (w_exact - i_dut_y);

  // Strictly-greater update keeps the earliest vector on ties.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_errCount <= '0;
      r_errMax   <= '0;
      r_errSum   <= '0;
      r_worstVec <= '0;
    end else if (w_startSweep) begin
      r_errCount <= '0;
      r_errMax   <= '0;
      r_errSum   <= '0;
      r_worstVec <= '0;
    end else if (w_dValid && (w_err != '0)) begin
      r_errCount <= r_errCount + 1'b1;
      r_errSum   <= r_errSum + {{CW{1'b0}}, w_err};
      if (w_err > r_errMax) begin
        r_errMax   <= w_err;
        r_worstVec <= {w_dA, w_dB};
      end
    end
  end

  assign o_err_count = r_errCount;
  assign o_err_max   = r_errMax;
  assign o_err_sum   = r_errSum;
  assign o_worst_vec = r_worstVec;

endmodule

// File: tb/tb_abs_diff_err_sweep.sv
// Directed bench for abs_diff_err_sweep: a LAT=0 instance with a selectable faulty
// abs_diff model and a LAT=2 instance behind a two-stage ideal abs_diff pipe.
module tb_abs_diff_err_sweep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, abort0 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic        busy0, done0, dutValid0, busy2, done2, dutValid2;
  logic [5:0]  dutA0, dutB0, dutY0, dutA2, dutB2, dutY2, y2a;
  logic [12:0] errCount0, errCount2;
  logic [5:0]  errMax0, errMax2;
  logic [17:0] errSum0, errSum2;
  logic [11:0] worstVec0, worstVec2;
  logic [1:0]  mode0 = 2'd0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  abs_diff_err_sweep #(.WIDTH(6), .LAT(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_abort(abort0),
    .o_busy(busy0), .o_done(done0), .o_dut_a(dutA0), .o_dut_b(dutB0),
    .o_dut_valid(dutValid0), .i_dut_y(dutY0), .o_err_count(errCount0),
    .o_err_max(errMax0), .o_err_sum(errSum0), .o_worst_vec(worstVec0));

  abs_diff_err_sweep #(.WIDTH(6), .LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_abort(abort2),
    .o_busy(busy2), .o_done(done2), .o_dut_a(dutA2), .o_dut_b(dutB2),
    .o_dut_valid(dutValid2), .i_dut_y(dutY2), .o_err_count(errCount2),
    .o_err_max(errMax2), .o_err_sum(errSum2), .o_worst_vec(worstVec2));

  function automatic logic [5:0] absDiff(input logic [5:0] a, input logic [5:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Device models: 0 ideal, 1 result bit0 stuck-at-0, 2 output tied to zero.
  always_comb begin
    case (mode0)
      2'd0:    dutY0 = absDiff(dutA0, dutB0);
      2'd1:    dutY0 = absDiff(dutA0, dutB0) & 6'h3E;
      default: dutY0 = 6'd0;
    endcase
  end

  always @(posedge clk) begin
    y2a   <= absDiff(dutA2, dutB2);
    dutY2 <= y2a;
  end

  // Starts a sweep (start sampled at edge 0) and follows it until done or a cycle budget.
  task automatic run_sweep(input bit useLat2, input int restartAt, output int doneCyc,
                           output int busyCnt, output logic [11:0] heldVec, output logic heldValid);
    doneCyc   = 0;
    busyCnt   = 0;
    heldVec   = '0;
    heldValid = 1'b1;
    @(negedge clk);
    if (useLat2) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      @(negedge clk);
      if (useLat2) start2 = (cyc == restartAt); else start0 = (cyc == restartAt);
      if (useLat2 ? busy2 : busy0) busyCnt++;
      if (cyc == 4097) begin
        heldVec   = useLat2 ? {dutA2, dutB2} : {dutA0, dutB0};
        heldValid = useLat2 ? dutValid2 : dutValid0;
      end
      if (useLat2 ? done2 : done0) begin
        doneCyc = cyc;
        break;
      end
    end
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0 || dutValid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ctrl0 got busy=%b done=%b valid=%b want 0 0 0", busy0, done0, dutValid0); end
    vectors++; if ({dutA0, dutB0} !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_vec0 got %h want 000", {dutA0, dutB0}); end
    vectors++; if (errCount0 !== 13'd0 || errMax0 !== 6'd0 || errSum0 !== 18'd0 || worstVec0 !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_metrics0 got %0d %0d %0d %h want all 0", errCount0, errMax0, errSum0, worstVec0); end
    vectors++; if (busy2 !== 1'b0 || done2 !== 1'b0 || dutValid2 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ctrl2 got busy=%b done=%b valid=%b want 0 0 0", busy2, done2, dutValid2); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ideal();
    int doneCyc, busyCnt;
    logic [11:0] heldVec;
    logic heldValid;
    mode0 = 2'd0;
    run_sweep(1'b0, 0, doneCyc, busyCnt, heldVec, heldValid);
    vectors++; if (doneCyc !== 4097) begin miscompares++; $display("[TB] FAIL ideal_done_cycle got %0d want 4097", doneCyc); end
    vectors++; if (busyCnt !== 4096) begin miscompares++; $display("[TB] FAIL ideal_busy_cycles got %0d want 4096", busyCnt); end
    vectors++; if (heldVec !== 12'hFFF || heldValid !== 1'b0) begin miscompares++; $display("[TB] FAIL ideal_done_outputs got vec=%h valid=%b want FFF 0", heldVec, heldValid); end
    vectors++; if (errCount0 !== 13'd0 || errMax0 !== 6'd0 || errSum0 !== 18'd0 || worstVec0 !== 12'h000) begin miscompares++; $display("[TB] FAIL ideal_metrics got %0d %0d %0d %h want all 0", errCount0, errMax0, errSum0, worstVec0); end
    @(negedge clk);
    vectors++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL ideal_done_pulse got done=%b busy=%b want 0 0", done0, busy0); end
  endtask

  task automatic test_stuck_bit0();
    int doneCyc, busyCnt;
    logic [11:0] heldVec;
    logic heldValid;
    mode0 = 2'd1;
    run_sweep(1'b0, 0, doneCyc, busyCnt, heldVec, heldValid);
    vectors++; if (doneCyc !== 4097) begin miscompares++; $display("[TB] FAIL stuck_done_cycle got %0d want 4097", doneCyc); end
    vectors++; if (errCount0 !== 13'd2048) begin miscompares++; $display("[TB] FAIL stuck_err_count got %0d want 2048", errCount0); end
    vectors++; if (errMax0 !== 6'd1) begin miscompares++; $display("[TB] FAIL stuck_err_max got %0d want 1", errMax0); end
    vectors++; if (errSum0 !== 18'd2048) begin miscompares++; $display("[TB] FAIL stuck_err_sum got %0d want 2048", errSum0); end
    vectors++; if (worstVec0 !== 12'h001) begin miscompares++; $display("[TB] FAIL stuck_worst_vec got %h want 001", worstVec0); end
  endtask

  task automatic check_zero_metrics(input string tag);
    vectors++; if (errCount0 !== 13'd4032) begin miscompares++; $display("[TB] FAIL %s_err_count got %0d want 4032", tag, errCount0); end
    vectors++; if (errMax0 !== 6'd63) begin miscompares++; $display("[TB] FAIL %s_err_max got %0d want 63", tag, errMax0); end
    vectors++; if (errSum0 !== 18'd87360) begin miscompares++; $display("[TB] FAIL %s_err_sum got %0d want 87360", tag, errSum0); end
    vectors++; if (worstVec0 !== 12'h03F) begin miscompares++; $display("[TB] FAIL %s_worst_vec got %h want 03F", tag, worstVec0); end
  endtask

  task automatic test_tied_zero();
    int doneCyc, busyCnt;
    logic [11:0] heldVec;
    logic heldValid;
    mode0 = 2'd2;
    run_sweep(1'b0, 0, doneCyc, busyCnt, heldVec, heldValid);
    vectors++; if (doneCyc !== 4097) begin miscompares++; $display("[TB] FAIL zero_done_cycle got %0d want 4097", doneCyc); end
    check_zero_metrics("zero");
  endtask

  task automatic test_latency2();
    int doneCyc, busyCnt;
    logic [11:0] heldVec;
    logic heldValid;
    run_sweep(1'b1, 0, doneCyc, busyCnt, heldVec, heldValid);
    vectors++; if (doneCyc !== 4099) begin miscompares++; $display("[TB] FAIL lat2_done_cycle got %0d want 4099", doneCyc); end
    vectors++; if (busyCnt !== 4098) begin miscompares++; $display("[TB] FAIL lat2_busy_cycles got %0d want 4098", busyCnt); end
    vectors++; if (heldVec !== 12'hFFF || heldValid !== 1'b0) begin miscompares++; $display("[TB] FAIL lat2_drain_outputs got vec=%h valid=%b want FFF 0", heldVec, heldValid); end
    vectors++; if (errCount2 !== 13'd0 || errMax2 !== 6'd0 || errSum2 !== 18'd0 || worstVec2 !== 12'h000) begin miscompares++; $display("[TB] FAIL lat2_metrics got %0d %0d %0d %h want all 0", errCount2, errMax2, errSum2, worstVec2); end
  endtask

  task automatic test_abort();
    int doneCyc, busyCnt, sawDone;
    logic [11:0] heldVec;
    logic heldValid;
    mode0 = 2'd2;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    vectors++; if (dutA0 !== 6'd1 || dutB0 !== 6'd35 || dutValid0 !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_run_vec got a=%0d b=%0d valid=%b want 1 35 1", dutA0, dutB0, dutValid0); end
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    vectors++; if (busy0 !== 1'b0 || dutValid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_to_idle got busy=%b valid=%b want 0 0", busy0, dutValid0); end
    sawDone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || busy0) sawDone++;
    end
    vectors++; if (sawDone !== 0) begin miscompares++; $display("[TB] FAIL abort_no_done got %0d active cycles want 0", sawDone); end
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_beats_start got busy=%b want 0", busy0); end
    run_sweep(1'b0, 0, doneCyc, busyCnt, heldVec, heldValid);
    vectors++; if (doneCyc !== 4097) begin miscompares++; $display("[TB] FAIL abort_resweep_done got %0d want 4097", doneCyc); end
    check_zero_metrics("abort_resweep");
  endtask

  task automatic test_back_to_back();
    int doneCyc, busyCnt;
    logic [11:0] heldVec;
    logic heldValid;
    mode0 = 2'd1;
    run_sweep(1'b0, 500, doneCyc, busyCnt, heldVec, heldValid);
    vectors++; if (doneCyc !== 4097) begin miscompares++; $display("[TB] FAIL restart_done_cycle got %0d want 4097", doneCyc); end
    vectors++; if (errCount0 !== 13'd2048 || errSum0 !== 18'd2048) begin miscompares++; $display("[TB] FAIL restart_metrics got %0d %0d want 2048 2048", errCount0, errSum0); end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL start_in_done got busy=%b want 0", busy0); end
  endtask

  task automatic test_reset_mid_sweep();
    mode0 = 2'd2;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst = 1'b1;
    #1;
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0 || dutValid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_ctrl got busy=%b done=%b valid=%b want 0 0 0", busy0, done0, dutValid0); end
    vectors++; if ({dutA0, dutB0} !== 12'h000) begin miscompares++; $display("[TB] FAIL rst_mid_vec got %h want 000", {dutA0, dutB0}); end
    vectors++; if (errCount0 !== 13'd0 || errMax0 !== 6'd0 || errSum0 !== 18'd0 || worstVec0 !== 12'h000) begin miscompares++; $display("[TB] FAIL rst_mid_metrics got %0d %0d %0d %h want all 0", errCount0, errMax0, errSum0, worstVec0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_release_idle got busy=%b want 0", busy0); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck_bit0();
    test_tied_zero();
    test_latency2();
    test_abort();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
